pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Parameters
REQ-001 SHALL provide ADDR_W, default 32: width of every address port and of the pc register.
REQ-002 SHALL provide RESET_PC, default 32'h0000_0000: value pc holds in reset and while ce is disabled.
REQ-003 SHALL provide STEP, default 4: sequential increment; STEP is a power of two, at least 1.
REQ-004 SHALL provide STALL_W, default 6: width of the stall vector; only bit 0 is consumed by this block.
REQ-005 SHALL provide ALIGN_CHECK, default 1: when 1, redirect targets are checked against STEP alignment.

Interface
REQ-006 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port stall  in  STALL_W  pipeline stall vector; bit 0 = 1 holds the PC.
REQ-009 SHALL have port flush_i  in  1  exception/flush redirect request.
REQ-010 SHALL have port new_pc_i  in  ADDR_W  flush target.
REQ-011 SHALL have port branch_flag_i  in  1  branch/jump taken, from decode.
REQ-012 SHALL have port branch_addr_i  in  ADDR_W  branch target.
REQ-013 SHALL have port pc  out  ADDR_W  current fetch address (registered).
REQ-014 SHALL have port ce  out  1  instruction memory chip enable (registered).
REQ-015 SHALL have port pend_o  out  1  a branch captured during a stall is pending (registered).
REQ-016 SHALL have port addr_err_o  out  1  one-cycle misaligned-target pulse (registered).

Function
REQ-017 SHALL implement a two-state FSM with states OFF (ce=0) and RUN (ce=1); rst forces OFF; OFF goes to RUN on the first edge with rst=0; RUN stays in RUN until rst.
REQ-018 SHALL load pc with RESET_PC on every edge where the FSM is in OFF, so the first RUN cycle presents pc=RESET_PC.
REQ-019 SHALL, in RUN, select the next pc at each edge by this priority: flush_i, then stall[0] hold, then branch_flag_i, then the pending branch, then sequential.
REQ-020 SHALL apply flush_i in RUN regardless of stall: pc<=new_pc_i, pending cleared, branch_flag_i ignored that cycle.
REQ-021 SHALL, when stall[0]=1 and flush_i=0, hold pc; if branch_flag_i=1, capture branch_addr_i into the pending register and set pend_o; a later branch_flag_i during the same stall overwrites the captured address.
REQ-022 SHALL, when stall[0]=0 and branch_flag_i=1, set pc<=branch_addr_i and clear pending; the live branch wins over a stale pending one.
REQ-023 SHALL, when stall[0]=0, branch_flag_i=0 and pend_o=1, set pc<=pending address and clear pend_o.
REQ-024 SHALL otherwise set pc<=pc+STEP, truncated to ADDR_W bits; 2^ADDR_W-STEP wraps to 0 without error.
REQ-025 SHALL, when ALIGN_CHECK=1 and an applied or captured target has nonzero bits [log2(STEP)-1:0], force those bits to 0 and assert addr_err_o for exactly the next cycle; sequential steps never raise addr_err_o.
REQ-026 SHALL tie addr_err_o to 0 and use targets unmodified when ALIGN_CHECK=0 or STEP=1.
REQ-027 SHALL ignore flush_i, branch_flag_i and stall while in OFF; nothing is captured while in OFF.
REQ-028 SHALL be fully synchronous with no combinational path from any input to any output.

Reset
REQ-029 SHALL, on an edge with rst=1, set state=OFF, ce=0, pc=RESET_PC, pend_o=0, pending address=0, addr_err_o=0; rst has priority over all inputs.
REQ-030 SHALL, when rst is asserted mid-operation (including while stalled with a branch pending), discard the pending branch; after release the next fetch starts at RESET_PC.

Verification
REQ-031 Reset release: hold rst for 3 cycles, then release with no stall -> ce=0 and pc=0 during reset; ce=1 with pc=0x0 on the first cycle after release; then pc=0x4, then 0x8.
REQ-032 Branch under stall: stall[0]=1 for 3 cycles, branch_flag_i pulsed once with 0x100 in cycle 1 -> pc held; pend_o=1 from cycle 2; after stall drops, pc=0x100, then 0x104; pend_o=0.
REQ-033 Flush priority: stall[0]=1, branch_flag_i=1 with 0x200 and flush_i=1 with 0x80 in the same cycle -> pc=0x80 next cycle; pend_o=0; 0x200 never appears.
REQ-034 Misaligned target: ALIGN_CHECK=1, STEP=4, branch to 0x1006 -> pc=0x1004; addr_err_o high for exactly one cycle.
REQ-035 Wrap: ADDR_W=8, pc=0xFC with no stall -> next pc=0x00; addr_err_o=0.
REQ-036 Reset mid-pending: capture 0x300 under stall, then assert rst for one cycle -> pend_o=0; after release the first pc values are RESET_PC then RESET_PC+4, never 0x300.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with stall-captured branch, flush redirect and target alignment check
module pc_gen #(
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter int unsigned          STEP        = 4,
    parameter int unsigned          STALL_W     = 6,
    parameter bit                   ALIGN_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   new_pc_i,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_addr_i,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                pend_o,
    output logic                addr_err_o
);

    typedef enum logic {OFF = 1'b0, RUN = 1'b1} state_t;

    localparam bit              ALIGN_EN  = ALIGN_CHECK && (STEP > 1);
    localparam logic [ADDR_W-1:0] LOW_BITS = ALIGN_EN ? ADDR_W'(STEP - 1) : '0;
    localparam logic [ADDR_W-1:0] STEP_W   = ADDR_W'(STEP);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic                ce_q, ce_d;

    // Only stall[0] matters here; the upper pipeline bits belong to later stages.
    logic                unused_stall;
    assign unused_stall = ^stall;

    logic [ADDR_W-1:0]   new_pc_al, branch_al;
    logic                new_pc_bad, branch_bad;

    assign new_pc_al  = new_pc_i & ~LOW_BITS;
    assign branch_al  = branch_addr_i & ~LOW_BITS;
    assign new_pc_bad = |(new_pc_i & LOW_BITS);
    assign branch_bad = |(branch_addr_i & LOW_BITS);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pend_d      = pend_q;
        err_d       = 1'b0;
        ce_d        = 1'b0;
        unique case (state_q)
            OFF: begin
                state_d = RUN;
                ce_d    = 1'b1;
                pc_d    = RESET_PC;
            end
            RUN: begin
                ce_d = 1'b1;
                if (flush_i) begin
                    pc_d   = new_pc_al;
                    pend_d = 1'b0;
                    err_d  = new_pc_bad;
                end else if (stall[0]) begin
                    if (branch_flag_i) begin
                        pend_addr_d = branch_al;
                        pend_d      = 1'b1;
                        err_d       = branch_bad;
                    end
                end else if (branch_flag_i) begin
                    pc_d   = branch_al;
                    pend_d = 1'b0;
                    err_d  = branch_bad;
                end else if (pend_q) begin
                    // Captured address was already aligned (and flagged) when stored.
                    pc_d   = pend_addr_q;
                    pend_d = 1'b0;
                end else begin
                    pc_d = pc_q + STEP_W;
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OFF;
            ce_q        <= 1'b0;
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ce_q        <= ce_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            err_q       <= err_d;
        end
    end

    assign pc         = pc_q;
    assign ce         = ce_q;
    assign pend_o     = pend_q;
    assign addr_err_o = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed bench for pc_gen (32-bit main instance plus 8-bit wrap instance)
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;

    logic [31:0] pc;
    logic        ce, pend_o, addr_err_o;
    logic [7:0]  pc8;
    logic        ce8, pend8, err8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_PC(32'h0), .STEP(4), .STALL_W(6), .ALIGN_CHECK(1'b1)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i),
        .branch_flag_i(branch_flag_i),
        .branch_addr_i(branch_addr_i),
        .pc           (pc),
        .ce           (ce),
        .pend_o       (pend_o),
        .addr_err_o   (addr_err_o)
    );

    pc_gen #(.ADDR_W(8), .RESET_PC(8'h0), .STEP(4), .STALL_W(6), .ALIGN_CHECK(1'b1)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush_i      (flush_i),
        .new_pc_i     (new_pc_i[7:0]),
        .branch_flag_i(branch_flag_i),
        .branch_addr_i(branch_addr_i[7:0]),
        .pc           (pc8),
        .ce           (ce8),
        .pend_o       (pend8),
        .addr_err_o   (err8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_ce,
                           input logic e_pend, input logic e_err);
        chk({tag, ".pc"},   pc,         e_pc);
        chk({tag, ".ce"},   32'(ce),    32'(e_ce));
        chk({tag, ".pend"}, 32'(pend_o), 32'(e_pend));
        chk({tag, ".err"},  32'(addr_err_o), 32'(e_err));
    endtask

    initial begin
        rst = 1'b1; stall = '0; flush_i = 1'b0; new_pc_i = '0;
        branch_flag_i = 1'b0; branch_addr_i = '0;

        // Reset release
        step(); chk_all("rst1", 32'h0, 1'b0, 1'b0, 1'b0);
        step(); chk_all("rst2", 32'h0, 1'b0, 1'b0, 1'b0);
        step(); chk_all("rst3", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst.ce8", 32'(ce8), 32'h0);
        rst = 1'b0;
        step(); chk_all("run0", 32'h0, 1'b1, 1'b0, 1'b0);
        step(); chk_all("run1", 32'h4, 1'b1, 1'b0, 1'b0);
        step(); chk_all("run2", 32'h8, 1'b1, 1'b0, 1'b0);

        // Branch captured under a three-cycle stall
        stall = 6'b000001; branch_flag_i = 1'b1; branch_addr_i = 32'h100;
        step(); chk_all("stl1", 32'h8, 1'b1, 1'b1, 1'b0);
        branch_flag_i = 1'b0;
        step(); chk_all("stl2", 32'h8, 1'b1, 1'b1, 1'b0);
        step(); chk_all("stl3", 32'h8, 1'b1, 1'b1, 1'b0);
        stall = '0;
        step(); chk_all("pend_go", 32'h100, 1'b1, 1'b0, 1'b0);
        step(); chk_all("pend_seq", 32'h104, 1'b1, 1'b0, 1'b0);

        // Upper stall bits alone do not hold the PC
        stall = 6'b111110;
        step(); chk_all("stall_hi", 32'h108, 1'b1, 1'b0, 1'b0);

        // Later branch in the same stall overwrites the captured one
        stall = 6'b000001; branch_flag_i = 1'b1; branch_addr_i = 32'h400;
        step();
        branch_addr_i = 32'h500;
        step(); chk_all("ovw_hold", 32'h108, 1'b1, 1'b1, 1'b0);
        stall = '0; branch_flag_i = 1'b0;
        step(); chk_all("ovw_go", 32'h500, 1'b1, 1'b0, 1'b0);

        // Live branch beats a stale pending one
        stall = 6'b000001; branch_flag_i = 1'b1; branch_addr_i = 32'h600;
        step();
        stall = '0; branch_addr_i = 32'h700;
        step(); chk_all("live", 32'h700, 1'b1, 1'b0, 1'b0);
        branch_flag_i = 1'b0;
        step(); chk_all("live_seq", 32'h704, 1'b1, 1'b0, 1'b0);

        // Flush beats stall and branch
        stall = 6'b000001; branch_flag_i = 1'b1; branch_addr_i = 32'h200;
        flush_i = 1'b1; new_pc_i = 32'h80;
        step(); chk_all("flush", 32'h80, 1'b1, 1'b0, 1'b0);
        stall = '0; branch_flag_i = 1'b0; flush_i = 1'b0;
        step(); chk_all("flush_seq", 32'h84, 1'b1, 1'b0, 1'b0);

        // Misaligned live branch
        branch_flag_i = 1'b1; branch_addr_i = 32'h1006;
        step(); chk_all("mis_br", 32'h1004, 1'b1, 1'b0, 1'b1);
        branch_flag_i = 1'b0;
        step(); chk_all("mis_br_next", 32'h1008, 1'b1, 1'b0, 1'b0);

        // Misaligned captured branch
        stall = 6'b000001; branch_flag_i = 1'b1; branch_addr_i = 32'h2003;
        step(); chk_all("mis_cap", 32'h1008, 1'b1, 1'b1, 1'b1);
        branch_flag_i = 1'b0;
        step(); chk_all("mis_cap2", 32'h1008, 1'b1, 1'b1, 1'b0);
        stall = '0;
        step(); chk_all("mis_cap_go", 32'h2000, 1'b1, 1'b0, 1'b0);

        // Misaligned flush target
        flush_i = 1'b1; new_pc_i = 32'h3002;
        step(); chk_all("mis_fl", 32'h3000, 1'b1, 1'b0, 1'b1);
        flush_i = 1'b0;

        // 8-bit wrap
        flush_i = 1'b1; new_pc_i = 32'hFC;
        step();
        chk("wrap.pre8", 32'(pc8), 32'hFC);
        flush_i = 1'b0;
        step();
        chk("wrap.pc8", 32'(pc8), 32'h00);
        chk("wrap.err8", 32'(err8), 32'h0);
        chk_all("wrap32", 32'h100, 1'b1, 1'b0, 1'b0);

        // Reset discards a pending branch
        stall = 6'b000001; branch_flag_i = 1'b1; branch_addr_i = 32'h300;
        step(); chk_all("rp_cap", 32'h100, 1'b1, 1'b1, 1'b0);
        branch_flag_i = 1'b0; rst = 1'b1;
        step(); chk_all("rp_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; stall = '0;
        step(); chk_all("rp_run0", 32'h0, 1'b1, 1'b0, 1'b0);
        step(); chk_all("rp_run1", 32'h4, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish within 100000 time units");
        $fatal(1);
    end

endmodule
